// File: rtl/kerygma_memsplit_ram_slave.sv
// kerygma_memsplit_ram_slave
//   Responder end of the MemSplit32 split-transaction memory interface.
//   Single-port word RAM with byte enables, a fixed-latency read-response
//   pipeline and a bounded number of in-flight reads.
//
// Ports:
//   clk_i    in   1   clock, all state updates on the rising edge
//   rst_ni   in   1   synchronous active-low reset
//   req_i    in   1   request valid from the master
//   ack_o    out  1   request accepted (transaction when req_i && ack_o)
//   addr_i   in  32   byte address; word index = addr_i[ADDR_WIDTH_WORDS+1:2]
//   we_i     in   1   1 = write, 0 = read
//   wdata_i  in  32   write data
//   be_i     in   4   byte enables, be_i[k] covers wdata_i[8k+7:8k]
//   resp_o   out  1   read response valid, one pulse per read
//   rdata_o  out 32   read data, zero whenever resp_o is low
module kerygma_memsplit_ram_slave #(
    parameter int unsigned ADDR_WIDTH_WORDS = 10,
    parameter int unsigned READ_LATENCY     = 2,
    parameter int unsigned MAX_OUTSTANDING  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        ack_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        resp_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH_WORDS;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]                 mem [DEPTH];
    logic [ADDR_WIDTH_WORDS-1:0] word_idx;
    logic [READ_LATENCY-1:0]     pipe_valid;
    logic [31:0]                 pipe_data [READ_LATENCY];
    logic [CNT_W-1:0]            outstanding;
    logic                        resp_now;
    logic                        accept;
    logic                        rd_fire;
    logic                        wr_fire;
    logic                        unused_addr_bits;

    // Upper address bits alias modulo RAM size; the byte offset is ignored.
    assign word_idx         = addr_i[ADDR_WIDTH_WORDS+1:2];
    assign unused_addr_bits = ^{addr_i[31:ADDR_WIDTH_WORDS+2], addr_i[1:0]};

    // A retiring response frees a slot in the same cycle, so a full
    // counter does not cost a bubble when responses are streaming out.
    assign resp_now = pipe_valid[READ_LATENCY-1];
    assign accept   = rst_ni && req_i && (we_i || (outstanding < CNT_MAX) || resp_now);
    assign ack_o    = accept;
    assign rd_fire  = accept && !we_i;
    assign wr_fire  = accept && we_i;

    // Gated by rst_ni so the outputs are quiet for the whole reset cycle,
    // even before the pipeline registers have been cleared.
    assign resp_o  = rst_ni && resp_now;
    assign rdata_o = resp_o ? pipe_data[READ_LATENCY-1] : '0;

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Data stages carry no reset; only the valids qualify them.
    // The read sees the pre-edge RAM word, i.e. all writes of earlier cycles.
    always_ff @(posedge clk_i) begin
        if (rd_fire) begin
            pipe_data[0] <= mem[word_idx];
        end
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= rd_fire;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else begin
            case ({rd_fire, resp_now})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
